// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule types, RCON table and S-box helper functions.
package aes_pkg;
  typedef logic [7:0] rcon_t;
  typedef enum logic [1:0] {IDLE, GEN, EMIT} keyexp_state_t;
  localparam int NR_AES128 = 10;
  // Padded to 16 entries so a 4-bit round+1 index never leaves the table
  localparam rcon_t RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                  8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, a, b;
    p = 8'h00;
    a = x;
    b = z;
    for (int k = 0; k < 8; k++) begin
      p = b[0] ? p ^ a : p;
      a = a[7] ? {a[6:0], 1'b0} ^ 8'h1b : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction
  // Multiplicative inverse as x^254, followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
endpackage

// File: rtl/aes_key_expand_key_round.sv
// key_round: one combinational AES-128 key-schedule step (cur -> next round key).
module key_round
  import aes_pkg::*;
(
  input  logic [127:0] cur,
  input  rcon_t        rcon,
  output logic [127:0] next
);
  logic [31:0] sw, t, w4, w5, w6, w7;
  subword u_subword (.a({cur[23:0], cur[31:24]}), .y(sw));
  assign t  = sw ^ {rcon, 24'h0};
  assign w4 = cur[127:96] ^ t;
  assign w5 = cur[95:64] ^ w4;
  assign w6 = cur[63:32] ^ w5;
  assign w7 = cur[31:0] ^ w6;
  assign next = {w4, w5, w6, w7};
endmodule

// File: rtl/subword.sv
// subword: AES SubWord, four parallel S-box lookups on a 32-bit word.
module subword
  import aes_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);
  for (genvar i = 0; i < 4; i++) begin : g_sbox
    assign y[8*i +: 8] = sbox(a[8*i +: 8]);
  end
endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand: sequential AES-128 key schedule emitting round keys over valid/ready.
// Define AES_KEYEXP_REVERSE_EN to precompute all keys and emit them NR..0.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int NR = NR_AES128
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         busy
);
  if (NR != NR_AES128) begin : g_nr_check
    $error("aes_key_expand supports only NR=10");
  end
  localparam logic [3:0] LAST = 4'(NR);
  keyexp_state_t state, state_n;
  logic [127:0] cur, nxt;
  logic [3:0] round;
  logic acc, adv;
  assign acc = key_valid && key_ready;
  assign adv = rk_valid && rk_ready;
  assign key_ready = state == IDLE;
  assign busy = state != IDLE;
  assign rk_valid = state == EMIT;
  assign rk_idx = round;
  key_round u_key_round (.cur(cur), .rcon(RCON[round + 4'd1]), .next(nxt));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
`ifdef AES_KEYEXP_REVERSE_EN
  logic [127:0] key_buf [0:NR];
  always_comb
    state_n = acc ? GEN :
              (state == GEN && round == LAST - 4'd1) ? EMIT :
              (adv && round == 4'd0) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= '0;
      round <= '0;
    end else if (acc) begin
      cur <= key;
      round <= '0;
    end else if (state == GEN) begin
      cur <= nxt;
      round <= round + 4'd1;
    end else if (adv && round != 4'd0) begin
      round <= round - 4'd1;
    end
  always_ff @(posedge clk)
    if (acc) key_buf[0] <= key;
    else if (state == GEN) key_buf[round + 4'd1] <= nxt;
  assign rk = rk_valid ? key_buf[round] : '0;
`else
  always_comb
    state_n = acc ? EMIT : (adv && round == LAST) ? IDLE : state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur <= '0;
      round <= '0;
    end else if (acc) begin
      cur <= key;
      round <= '0;
    end else if (adv && round != LAST) begin
      cur <= nxt;
      round <= round + 4'd1;
    end
  assign rk = cur;
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed self-checking bench for aes_key_expand (both build modes).
module tb_aes_key_expand;
  logic clk = 0, rst_n = 0, key_valid = 0, rk_ready = 0;
  logic [127:0] key = '0;
  logic key_ready, rk_valid, busy;
  logic [127:0] rk;
  logic [3:0] rk_idx;
  int checks = 0, failures = 0;
  logic [127:0] fips [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  localparam logic [127:0] Z1 = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand dut (.clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key(key), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk(rk), .rk_idx(rk_idx), .busy(busy));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0 || rk !== '0 || rk_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset: key_ready=%b rk_valid=%b busy=%b rk=%h idx=%0d, want 1 0 0 0 0",
               key_ready, rk_valid, busy, rk, rk_idx);
    end
    rst_n = 1;
    tick();
    checks++;
    if (key_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: key_ready=%b busy=%b, want 1 0", key_ready, busy);
    end
  endtask

`ifndef AES_KEYEXP_REVERSE_EN
  task automatic test_forward();
    rk_ready = 1;
    key_valid = 1;
    key = fips[0];
    tick();
    key_valid = 0;
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== fips[i] || busy !== 1'b1 || key_ready !== 1'b0) begin
        failures++;
        $display("FAIL fwd_beat%0d: valid=%b idx=%0d rk=%h busy=%b kr=%b, want 1 %0d %h 1 0",
                 i, rk_valid, rk_idx, rk, busy, key_ready, i, fips[i]);
      end
      tick();
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL fwd_end: valid=%b key_ready=%b busy=%b, want 0 1 0", rk_valid, key_ready, busy);
    end
  endtask

  task automatic test_stall();
    int n = 0, cyc = 0, r;
    rk_ready = 0;
    key_valid = 1;
    key = fips[0];
    tick();
    key_valid = 0;
    while (n <= 10 && cyc < 200) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(n) || rk !== fips[n]) begin
        failures++;
        $display("FAIL stall_beat%0d: valid=%b idx=%0d rk=%h, want 1 %0d %h", n, rk_valid, rk_idx, rk, n, fips[n]);
      end
      r = $urandom_range(0, 1);
      rk_ready = r[0];
      tick();
      n += r;
      cyc++;
    end
    rk_ready = 0;
    checks++;
    if (n != 11 || rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL stall_end: beats=%0d valid=%b key_ready=%b, want 11 0 1", n, rk_valid, key_ready);
    end
  endtask

  task automatic test_key_ignored();
    rk_ready = 1;
    key_valid = 1;
    key = fips[0];
    tick();
    key = '0;
    for (int i = 0; i <= 10; i++) begin
      checks++;
      if (rk_valid !== 1'b1 || key_ready !== 1'b0 || rk_idx !== 4'(i) || rk !== fips[i]) begin
        failures++;
        $display("FAIL ignore_beat%0d: valid=%b kr=%b idx=%0d rk=%h, want 1 0 %0d %h",
                 i, rk_valid, key_ready, rk_idx, rk, i, fips[i]);
      end
      tick();
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL ignore_gap: valid=%b key_ready=%b, want 0 1", rk_valid, key_ready);
    end
    tick();
    key_valid = 0;
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk !== '0) begin
      failures++;
      $display("FAIL ignore_second: valid=%b idx=%0d rk=%h, want 1 0 0", rk_valid, rk_idx, rk);
    end
    for (int i = 0; i < 12 && rk_valid; i++) tick();
  endtask

  task automatic test_zero_key();
    rk_ready = 1;
    key_valid = 1;
    key = '0;
    tick();
    key_valid = 0;
    for (int i = 0; i <= 10; i++) begin
      if (i == 1 || i == 10) begin
        checks++;
        if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== (i == 1 ? Z1 : Z10)) begin
          failures++;
          $display("FAIL zero_idx%0d: valid=%b idx=%0d rk=%h, want 1 %0d %h",
                   i, rk_valid, rk_idx, rk, i, i == 1 ? Z1 : Z10);
        end
      end
      tick();
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
      failures++;
      $display("FAIL zero_end: valid=%b key_ready=%b, want 0 1", rk_valid, key_ready);
    end
  endtask

  task automatic test_async_reset();
    rk_ready = 1;
    key_valid = 1;
    key = fips[0];
    tick();
    key_valid = 0;
    repeat (4) tick();
    rk_ready = 0;
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd4 || rk !== fips[4]) begin
      failures++;
      $display("FAIL pre_reset_idx4: valid=%b idx=%0d rk=%h, want 1 4 %h", rk_valid, rk_idx, rk, fips[4]);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || rk_idx !== 4'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%b busy=%b kr=%b idx=%0d, want 0 0 1 0", rk_valid, busy, key_ready, rk_idx);
    end
    tick();
    rst_n = 1;
    key_valid = 1;
    key = '0;
    tick();
    key_valid = 0;
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd0 || rk !== '0) begin
      failures++;
      $display("FAIL restart_idx0: valid=%b idx=%0d rk=%h, want 1 0 0", rk_valid, rk_idx, rk);
    end
    rk_ready = 1;
    tick();
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== 4'd1 || rk !== Z1) begin
      failures++;
      $display("FAIL restart_idx1: valid=%b idx=%0d rk=%h, want 1 1 %h", rk_valid, rk_idx, rk, Z1);
    end
    for (int i = 0; i < 12 && rk_valid; i++) tick();
  endtask
`else
  task automatic test_reverse();
    rk_ready = 1;
    key_valid = 1;
    key = fips[0];
    tick();
    key_valid = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rk_valid !== 1'b0 || busy !== 1'b1 || key_ready !== 1'b0) begin
        failures++;
        $display("FAIL rev_gen%0d: valid=%b busy=%b kr=%b, want 0 1 0", i, rk_valid, busy, key_ready);
      end
      tick();
    end
    for (int i = 10; i >= 0; i--) begin
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(i) || rk !== fips[i]) begin
        failures++;
        $display("FAIL rev_beat%0d: valid=%b idx=%0d rk=%h, want 1 %0d %h", i, rk_valid, rk_idx, rk, i, fips[i]);
      end
      tick();
    end
    checks++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rev_end: valid=%b key_ready=%b busy=%b, want 0 1 0", rk_valid, key_ready, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef AES_KEYEXP_REVERSE_EN
    test_reverse();
`else
    test_forward();
    test_stall();
    test_key_ignored();
    test_zero_key();
    test_async_reset();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
